// File: rtl/regfile_dump_reader.sv
// Sequential register-file read-back engine: walks an index range through one
// read port and streams each value out on a valid/ready interface with its index.
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_X0    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_idx,
    input  logic [ADDR_WIDTH-1:0] last_idx,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_idx,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] end_q;

    // Read port is only addressed while the READ cycle samples it.
    assign rf_addr = (state_q == StRead) ? cur_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cur_q   <= '0;
            end_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_idx   <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (first_idx <= last_idx) begin
                            cur_q   <= first_idx;
                            end_q   <= last_idx;
                            busy    <= 1'b1;
                            state_q <= StRead;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (abort) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        m_data  <= (ZERO_X0 && cur_q == '0) ? '0 : rf_data;
                        m_idx   <= cur_q;
                        m_last  <= (cur_q == end_q);
                        m_valid <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    // Abort takes priority over a same-cycle handshake.
                    if (abort) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= StRead;
                        end
                    end
                end
                StDone: begin
                    if (abort) begin
                        m_last <= 1'b0;
                    end
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Sequential read-back engine for the 32x32 register file. On a start pulse it walks a register index range through one register-file read port. It streams each register's value out on a valid/ready interface, tagged with its index. The block sits beside the core for debug, trace and self-check dumps, and never writes the register file.

Parameters:
DATA_WIDTH, 32, width of a register and of the stream data
ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)
ZERO_X0, 1, when 1 the value for index 0 is forced to 0 regardless of rf_data

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  request a dump; sampled only in IDLE
first_idx  input  ADDR_WIDTH  first register index, latched on accepted start
last_idx  input  ADDR_WIDTH  last register index (inclusive), latched on accepted start
abort  input  1  terminate an in-progress dump
rf_addr  output  ADDR_WIDTH  address to the register-file read port (combinational read)
rf_data  input  DATA_WIDTH  read data returned the same cycle for rf_addr
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word
m_data  output  DATA_WIDTH  register value
m_idx  output  ADDR_WIDTH  register index of m_data
m_last  output  1  word is the final one of the range
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final word is accepted
err  output  1  one-cycle pulse when a start is rejected because first_idx > last_idx

Behaviour:
- Reset (rst=0, async): state=IDLE; rf_addr, m_data, m_idx = 0; m_valid, m_last, busy, done, err = 0; latched indices = 0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rf_addr=0.
  - start=1 with first_idx<=last_idx: latch cur=first_idx and end=last_idx, then go to READ.
  - start=1 with first_idx>last_idx: err=1 for the next cycle only, remain in IDLE.
- READ (one cycle):
  - rf_addr=cur.
  - At the edge ending READ, register m_data=rf_data (0 if ZERO_X0 and cur==0), m_idx=cur, m_last=(cur==end).
  - Set m_valid=1 and go to SEND.
- SEND:
  - m_valid=1; m_data, m_idx and m_last are held stable until handshake (m_valid & m_ready at an edge).
  - On handshake with m_last=1: m_valid=0, go to DONE.
  - On handshake with m_last=0: m_valid=0, cur=cur+1, go to READ.
- DONE (one cycle): done=1, busy=1. The next state is IDLE, where done=0.
- Latency:
  - start accepted at edge N; READ occupies cycle N..N+1; m_valid=1 after edge N+1.
  - Peak throughput is one word per 2 cycles.
- start while busy=1 is ignored; no queuing.
- abort=1 in READ, SEND or DONE:
  - Next state is IDLE; m_valid, m_last and done are cleared.
  - abort wins over a simultaneous handshake, so no done pulse is produced.
  - abort in IDLE has no effect.
- Range 31..31 and 0..31 are legal. cur never wraps, because the range ends at end<=31 before increment.
- Index arithmetic is unsigned ADDR_WIDTH.
- The block assumes rf_data is not modified by a concurrent write during the READ cycle. Coherency is the caller's responsibility.
- Reset asserted mid-dump returns the block to IDLE immediately with all outputs at reset values.

Test Plan:
- Full dump: preload xk=0x100+k (x0 write ignored), start 0..31, m_ready=1 → 32 words in order idx 0..31; data 0x0, 0x101..0x11F; m_last only on idx 31; done pulse once; 64 cycles from start to last handshake.
- Backpressure: range 5..7, m_ready low for 3 cycles on each word → m_data/m_idx held stable while stalled; 3 words 0x105, 0x106, 0x107; no duplicates or drops.
- Range error: start with first=10, last=3 → err high exactly one cycle; busy stays 0; no m_valid.
- Single register: start 31..31 → one word idx 31, m_last=1, followed by done.
- Abort: start 0..31, assert abort during the SEND of idx 4 with m_ready=1 the same cycle → m_valid=0 next cycle, no done, busy=0; a subsequent start 2..2 yields idx 2 only.
- Async reset: pull rst low mid-SEND between clock edges → all outputs 0 immediately; start is ignored while rst=0.
